four_bit_comparator: RTL and testbench

- Registered magnitude comparator for two 4-bit operands, A and B.
- Produces a one-hot-plus-flag result vector R: less-than, equal, greater-than, not-equal.
- Used as a leaf datapath block wherever the design needs a compare, e.g. sort, branch-decision or threshold logic.
- One input pair is accepted per cycle; the result is registered with one cycle of latency.

---
 rtl/four_bit_comparator.sv | 86 ++++++++
 tb/tb_four_bit_comparator.sv | 128 ++++++++++++
 2 files changed

// File: rtl/four_bit_comparator.sv
// Registered magnitude comparator: MSB-first cascade over two operands,
// unsigned or two's-complement, one-cycle latency with valid tracking.
module four_bit_comparator #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             cmp_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [3:0]       R
);

  localparam int unsigned RW = 4;

  localparam logic [RW-1:0] R_LT    = 4'b1001;
  localparam logic [RW-1:0] R_EQ    = 4'b0010;
  localparam logic [RW-1:0] R_GT    = 4'b1100;
  localparam logic [RW-1:0] R_RESET = 4'b0000;

  logic [WIDTH-1:0] msb_flip_c;
  logic [WIDTH-1:0] a_key_c;
  logic [WIDTH-1:0] b_key_c;
  logic             gt_c;
  logic             lt_c;
  logic [RW-1:0]    cmp_c;

  logic [RW-1:0]    r_q;
  logic [RW-1:0]    r_d;
  logic             out_valid_q;
  logic             out_valid_d;

  // Flipping the sign bit turns a signed compare into an unsigned one.
  assign msb_flip_c = {cmp_signed, {(WIDTH-1){1'b0}}};
  assign a_key_c    = A ^ msb_flip_c;
  assign b_key_c    = B ^ msb_flip_c;

  // The first differing bit from the MSB decides; no difference means equal.
  always_comb begin
    gt_c = 1'b0;
    lt_c = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!gt_c && !lt_c) begin
        if (a_key_c[i] && !b_key_c[i]) begin
          gt_c = 1'b1;
        end else if (!a_key_c[i] && b_key_c[i]) begin
          lt_c = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cmp_c = R_EQ;
    if (lt_c) begin
      cmp_c = R_LT;
    end else if (gt_c) begin
      cmp_c = R_GT;
    end
  end

  // R only moves on a valid sample; otherwise it keeps the last result.
  always_comb begin
    r_d         = r_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      r_d = cmp_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= R_RESET;
      out_valid_q <= 1'b0;
    end else begin
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign R         = r_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_four_bit_comparator.sv
// Directed and exhaustive self-checking bench for four_bit_comparator.
module tb_four_bit_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       cmp_signed;
  logic [3:0] A;
  logic [3:0] B;
  logic       out_valid;
  logic [3:0] R;

  int n_total = 0;
  int n_pass  = 0;

  four_bit_comparator #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .cmp_signed (cmp_signed),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .R          (R)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_r(input logic [3:0] a, input logic [3:0] b, input logic s);
    int ia;
    int ib;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    if (ia < ib)      return 4'b1001;
    else if (ia > ib) return 4'b1100;
    else              return 4'b0010;
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed={v,R}=%b expected=%b", tag, obs, exp);
  endtask

  // Drive one cycle, then sample #1 after the edge.
  task automatic cycle(input logic r, input logic v, input logic s,
                       input logic [3:0] a, input logic [3:0] b);
    rst = r; in_valid = v; cmp_signed = s; A = a; B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic s, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] exp);
    cycle(1'b0, 1'b1, s, a, b);
    check(tag, {out_valid, R}, {1'b1, exp});
  endtask

  initial begin
    logic [3:0] e;

    // Reset held with valid input present
    cycle(1'b1, 1'b1, 1'b0, 4'b0101, 4'b1010);
    check("reset_c1", {out_valid, R}, 5'b0_0000);
    cycle(1'b1, 1'b1, 1'b0, 4'b0101, 4'b1010);
    check("reset_c2", {out_valid, R}, 5'b0_0000);
    cycle(1'b0, 1'b0, 1'b0, 4'b0101, 4'b1010);
    check("reset_release", {out_valid, R}, 5'b0_0000);

    // Unsigned directed, back to back
    step("u_0101_1010", 1'b0, 4'b0101, 4'b1010, 4'b1001);
    step("u_1010_0101", 1'b0, 4'b1010, 4'b0101, 4'b1100);
    step("u_1100_0011", 1'b0, 4'b1100, 4'b0011, 4'b1100);
    step("u_0011_1100", 1'b0, 4'b0011, 4'b1100, 4'b1001);
    step("u_1100_1100", 1'b0, 4'b1100, 4'b1100, 4'b0010);
    step("u_0011_0101", 1'b0, 4'b0011, 4'b0101, 4'b1001);
    step("u_0110_1001", 1'b0, 4'b0110, 4'b1001, 4'b1001);
    step("u_0111_1110", 1'b0, 4'b0111, 4'b1110, 4'b1001);
    step("u_0010_0100", 1'b0, 4'b0010, 4'b0100, 4'b1001);
    step("u_1000_1000", 1'b0, 4'b1000, 4'b1000, 4'b0010);
    step("u_1100_1010_a", 1'b0, 4'b1100, 4'b1010, 4'b1100);
    step("u_1100_1010_b", 1'b0, 4'b1100, 4'b1010, 4'b1100);
    step("u_0111_1000", 1'b0, 4'b0111, 4'b1000, 4'b1001);
    step("u_1111_0000", 1'b0, 4'b1111, 4'b0000, 4'b1100);

    // Signed directed
    step("s_1010_0101", 1'b1, 4'b1010, 4'b0101, 4'b1001);
    step("s_0111_1000", 1'b1, 4'b0111, 4'b1000, 4'b1100);
    step("s_1111_1111", 1'b1, 4'b1111, 4'b1111, 4'b0010);
    step("s_1111_0000", 1'b1, 4'b1111, 4'b0000, 4'b1001);
    step("s_1000_1111", 1'b1, 4'b1000, 4'b1111, 4'b1001);
    step("s_0000_0111", 1'b1, 4'b0000, 4'b0111, 4'b1001);

    // Valid gating: one pulse, then R holds
    step("gate_pulse", 1'b0, 4'b0011, 4'b0011, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000);
      check($sformatf("gate_hold_%0d", k), {out_valid, R}, 5'b0_0010);
    end

    // Reset mid-stream discards the pair presented with rst
    step("mid_first", 1'b0, 4'b0101, 4'b1010, 4'b1001);
    cycle(1'b1, 1'b1, 1'b0, 4'b1010, 4'b0101);
    check("mid_reset_edge", {out_valid, R}, 5'b0_0000);
    cycle(1'b0, 1'b0, 1'b0, 4'b1010, 4'b0101);
    check("mid_after_1", {out_valid, R}, 5'b0_0000);
    cycle(1'b0, 1'b0, 1'b0, 4'b1010, 4'b0101);
    check("mid_after_2", {out_valid, R}, 5'b0_0000);

    // Exhaustive sweep in both modes with invariants
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          e = ref_r(4'(a), 4'(b), 1'(s));
          cycle(1'b0, 1'b1, 1'(s), 4'(a), 4'(b));
          check($sformatf("sweep_s%0d_a%0d_b%0d", s, a, b), {out_valid, R}, {1'b1, e});
          check("inv_ne", {4'b0000, R[3]}, {4'b0000, ~R[1]});
          check("inv_onehot", 5'(32'(R[0]) + 32'(R[1]) + 32'(R[2])), 5'd1);
        end
      end
    end

    in_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
